// File: rtl/ahb_lite_pkg.sv
// Shared AHB-Lite types: transfer size encoding, descriptor layout and the
// HSIZE/HADDR alignment rule used by the bus-side buffers.
package ahb_lite_pkg;

  localparam int BUS_W = 32;

  typedef enum logic [1:0] {
    BYTE     = 2'b00,
    HALFWORD = 2'b01,
    WORD     = 2'b10
  } hsize_t;

  typedef struct packed {
    logic               hwrite;
    hsize_t             hsize;
    logic [BUS_W-1:0]   haddr;
    logic [BUS_W-1:0]   hdata;
  } ahb_txn_t;

  // Only the two address LSBs matter; the reserved size 2'b11 never aligns.
  function automatic logic is_aligned(input hsize_t hsize, input logic [1:0] addr_lo);
    logic ok;
    case (hsize)
      BYTE:     ok = 1'b1;
      HALFWORD: ok = ~addr_lo[0];
      WORD:     ok = (addr_lo == 2'b00);
      default:  ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/ahb_txn_fifo_mem.sv
// Descriptor storage: one synchronous write port, one asynchronous read port
// so the head entry can fall through to the consumer without a register stage.
module ahb_txn_fifo_mem #(
  parameter int W      = 68,
  parameter int DEPTH  = 8,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              HCLK,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [W-1:0]      wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [W-1:0]      rdata
);

  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge HCLK) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/ahb_txn_fifo.sv
// Transaction FIFO between the AHB-Lite bus front-end and the master sequencer:
// valid/ready on both sides, FWFT head, occupancy status and sticky error flags.
module ahb_txn_fifo
  import ahb_lite_pkg::*;
#(
  parameter int DATA_W    = BUS_W,
  parameter int DEPTH     = 8,
  parameter int AFULL_LVL = DEPTH - 2,
  parameter int ALIGN_CHK = 1
) (
  input  logic                     HCLK,
  input  logic                     resetn,
  input  logic                     flush,
  input  logic                     push_valid,
  output logic                     push_ready,
  input  logic                     push_hwrite,
  input  logic [1:0]               push_hsize,
  input  logic [DATA_W-1:0]        push_haddr,
  input  logic [DATA_W-1:0]        push_hdata,
  output logic                     pop_valid,
  input  logic                     pop_ready,
  output logic                     pop_hwrite,
  output logic [1:0]               pop_hsize,
  output logic [DATA_W-1:0]        pop_haddr,
  output logic [DATA_W-1:0]        pop_hdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty,
  output logic                     afull,
  output logic                     err_ovf,
  output logic                     err_udf,
  output logic                     err_align,
  input  logic                     err_clr
);

  localparam int ADDR_W = $clog2(DEPTH);
  localparam logic [ADDR_W:0] PTR_ONE   = 1;
  localparam logic [ADDR_W:0] AFULL_CNT = AFULL_LVL[ADDR_W:0];

  typedef struct packed {
    logic                hwrite;
    hsize_t              hsize;
    logic [DATA_W-1:0]   haddr;
    logic [DATA_W-1:0]   hdata;
  } txn_t;

  localparam int TXN_W = $bits(txn_t);

  logic [ADDR_W:0]   wr_ptr, rd_ptr;
  txn_t              wr_txn, rd_txn, head;
  logic [TXN_W-1:0]  rd_raw;
  logic              aligned;
  logic              push_fire, pop_fire, store;
  logic              ovf_set, udf_set, align_set;

  // Status comes straight from the pointers; the extra wrap bit separates full from empty.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]) &&
                 (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]);
  assign count = wr_ptr - rd_ptr;
  assign afull = (count >= AFULL_CNT);

  assign push_ready = ~full;
  assign pop_valid  = ~empty;

  assign aligned   = (ALIGN_CHK == 0) || is_aligned(hsize_t'(push_hsize), push_haddr[1:0]);
  assign push_fire = push_valid & push_ready;
  assign pop_fire  = pop_valid & pop_ready & ~flush;
  // A misaligned push still handshakes but never reaches storage.
  assign store     = push_fire & aligned & ~flush & resetn;

  assign ovf_set   = push_valid & full;
  assign udf_set   = pop_ready & empty;
  assign align_set = push_fire & ~aligned & ~flush;

  assign wr_txn = '{hwrite: push_hwrite,
                    hsize:  hsize_t'(push_hsize),
                    haddr:  push_haddr,
                    hdata:  push_hdata};

  ahb_txn_fifo_mem #(
    .W      (TXN_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .HCLK  (HCLK),
    .we    (store),
    .waddr (wr_ptr[ADDR_W-1:0]),
    .wdata (wr_txn),
    .raddr (rd_ptr[ADDR_W-1:0]),
    .rdata (rd_raw)
  );

  assign rd_txn = txn_t'(rd_raw);
  assign head   = empty ? '0 : rd_txn;

  assign pop_hwrite = head.hwrite;
  assign pop_hsize  = head.hsize;
  assign pop_haddr  = head.haddr;
  assign pop_hdata  = head.hdata;

  always_ff @(posedge HCLK) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (store)    wr_ptr <= wr_ptr + PTR_ONE;
      if (pop_fire) rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  // Sticky flags: a new event in the same cycle as err_clr keeps the flag set.
  always_ff @(posedge HCLK) begin
    if (!resetn) begin
      err_ovf   <= 1'b0;
      err_udf   <= 1'b0;
      err_align <= 1'b0;
    end else begin
      err_ovf   <= (err_ovf   & ~err_clr) | ovf_set;
      err_udf   <= (err_udf   & ~err_clr) | udf_set;
      err_align <= (err_align & ~err_clr) | align_set;
    end
  end

endmodule
